// File: rtl/meanshift_product_accumulator.sv
// ============================================================================
// Module      : meanshift_product_accumulator
// Description : Saturating per-window accumulator of signed products and
//               unsigned kernel weights, with a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module meanshift_product_accumulator #(
    parameter int PROD_W      = 24,
    parameter int WT_W        = 16,
    parameter int ACC_W       = 40,
    parameter int WSUM_W      = 32,
    parameter int MAX_SAMPLES = 441,
    parameter int CNT_W       = 10
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] s_prod,
    input  logic [WT_W-1:0]   s_wt,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ACC_W-1:0]  m_sum_prod,
    output logic [WSUM_W-1:0] m_sum_wt,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_sat,
    output logic              m_trunc,
    output logic              m_valid,
    input  logic              m_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0]  ACC_POS_LIM = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_NEG_LIM = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [WSUM_W-1:0] WSUM_LIM    = {WSUM_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_END     = CNT_W'(MAX_SAMPLES);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WSUM_W-1:0]   wsum_q, wsum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [ACC_W-1:0]    m_sum_prod_q, m_sum_prod_d;
    logic [WSUM_W-1:0]   m_sum_wt_q, m_sum_wt_d;
    logic [CNT_W-1:0]    m_count_q, m_count_d;
    logic                m_sat_q, m_sat_d;
    logic                m_trunc_q, m_trunc_d;
    logic                m_valid_q, m_valid_d;

    logic                first_beat;
    logic                accept;
    logic [ACC_W:0]      prod_ext;
    logic [ACC_W:0]      acc_base;
    logic [ACC_W:0]      acc_sum;
    logic                acc_ovf;
    logic [ACC_W-1:0]    acc_step;
    logic [WSUM_W:0]     wsum_base;
    logic [WSUM_W:0]     wsum_sum;
    logic                wsum_ovf;
    logic [WSUM_W-1:0]   wsum_step;
    logic [CNT_W-1:0]    cnt_step;
    logic                sat_step;
    logic                win_end;

    assign first_beat = (state_q == ST_IDLE);
    assign accept     = s_valid && (state_q != ST_HOLD);
    assign s_ready    = ap_rst_n && (state_q != ST_HOLD);

    // One guard bit above the accumulator width exposes overflow as a
    // disagreement between the two top bits of the sum.
    assign prod_ext  = {{(ACC_W+1-PROD_W){s_prod[PROD_W-1]}}, s_prod};
    assign acc_base  = first_beat ? '0 : {acc_q[ACC_W-1], acc_q};
    assign acc_sum   = acc_base + prod_ext;
    assign acc_ovf   = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    assign acc_step  = !acc_ovf ? acc_sum[ACC_W-1:0]
                     : (acc_sum[ACC_W] ? ACC_NEG_LIM : ACC_POS_LIM);

    assign wsum_base = first_beat ? '0 : {1'b0, wsum_q};
    assign wsum_sum  = wsum_base + {{(WSUM_W+1-WT_W){1'b0}}, s_wt};
    assign wsum_ovf  = wsum_sum[WSUM_W];
    assign wsum_step = wsum_ovf ? WSUM_LIM : wsum_sum[WSUM_W-1:0];

    assign cnt_step  = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign sat_step  = (first_beat ? 1'b0 : sat_q) | acc_ovf | wsum_ovf;
    assign win_end   = s_last || (cnt_step == CNT_END);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        wsum_d       = wsum_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        m_sum_prod_d = m_sum_prod_q;
        m_sum_wt_d   = m_sum_wt_q;
        m_count_d    = m_count_q;
        m_sat_d      = m_sat_q;
        m_trunc_d    = m_trunc_q;
        m_valid_d    = m_valid_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d  = acc_step;
                    wsum_d = wsum_step;
                    cnt_d  = cnt_step;
                    sat_d  = sat_step;
                    if (win_end) begin
                        state_d      = ST_HOLD;
                        m_sum_prod_d = acc_step;
                        m_sum_wt_d   = wsum_step;
                        m_count_d    = cnt_step;
                        m_sat_d      = sat_step;
                        m_trunc_d    = !s_last;
                        m_valid_d    = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            wsum_q       <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            m_sum_prod_q <= '0;
            m_sum_wt_q   <= '0;
            m_count_q    <= '0;
            m_sat_q      <= 1'b0;
            m_trunc_q    <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            wsum_q       <= wsum_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            m_sum_prod_q <= m_sum_prod_d;
            m_sum_wt_q   <= m_sum_wt_d;
            m_count_q    <= m_count_d;
            m_sat_q      <= m_sat_d;
            m_trunc_q    <= m_trunc_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_sum_prod = m_sum_prod_q;
    assign m_sum_wt   = m_sum_wt_q;
    assign m_count    = m_count_q;
    assign m_sat      = m_sat_q;
    assign m_trunc    = m_trunc_q;
    assign m_valid    = m_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_meanshift_product_accumulator.sv
// ============================================================================
// Module      : tb_meanshift_product_accumulator
// Description : Bench for meanshift_product_accumulator; a wide instance and a
//               narrow (saturation-prone) instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_meanshift_product_accumulator;

    localparam int PROD_W = 24;
    localparam int WT_W   = 16;
    localparam int CNT_W  = 10;
    localparam int MAXS   = 441;
    localparam int ACC_A  = 40;
    localparam int WSUM_A = 32;
    localparam int ACC_B  = 25;
    localparam int WSUM_B = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PROD_W-1:0] s_prod = '0;
    logic [WT_W-1:0]   s_wt = '0;
    logic              s_last = 1'b0;
    logic              s_valid = 1'b0;
    logic              m_ready = 1'b0;

    logic              rdy_a, sat_a, trunc_a, mv_a;
    logic [ACC_A-1:0]  sp_a;
    logic [WSUM_A-1:0] sw_a;
    logic [CNT_W-1:0]  cnt_a;
    logic              rdy_b, sat_b, trunc_b, mv_b;
    logic [ACC_B-1:0]  sp_b;
    logic [WSUM_B-1:0] sw_b;
    logic [CNT_W-1:0]  cnt_b;

    always #5 clk = ~clk;

    meanshift_product_accumulator #(
        .PROD_W(PROD_W), .WT_W(WT_W), .ACC_W(ACC_A), .WSUM_W(WSUM_A),
        .MAX_SAMPLES(MAXS), .CNT_W(CNT_W)
    ) u_dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_prod(s_prod), .s_wt(s_wt),
        .s_last(s_last), .s_valid(s_valid), .s_ready(rdy_a),
        .m_sum_prod(sp_a), .m_sum_wt(sw_a), .m_count(cnt_a), .m_sat(sat_a),
        .m_trunc(trunc_a), .m_valid(mv_a), .m_ready(m_ready)
    );

    meanshift_product_accumulator #(
        .PROD_W(PROD_W), .WT_W(WT_W), .ACC_W(ACC_B), .WSUM_W(WSUM_B),
        .MAX_SAMPLES(MAXS), .CNT_W(CNT_W)
    ) u_dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_prod(s_prod), .s_wt(s_wt),
        .s_last(s_last), .s_valid(s_valid), .s_ready(rdy_b),
        .m_sum_prod(sp_b), .m_sum_wt(sw_b), .m_count(cnt_b), .m_sat(sat_b),
        .m_trunc(trunc_b), .m_valid(mv_b), .m_ready(m_ready)
    );

    int n_err = 0;
    int n_chk = 0;

    // Window-level reference: running sums with clamping per the arithmetic rules.
    longint exp_acc_a, exp_ws_a, exp_acc_b, exp_ws_b;
    bit     exp_sat_a, exp_sat_b;
    int     exp_cnt = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint smax(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint umax(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    task automatic model_add(input longint p, input longint w);
        if (exp_cnt == 0) begin
            exp_acc_a = 0; exp_ws_a = 0; exp_sat_a = 0;
            exp_acc_b = 0; exp_ws_b = 0; exp_sat_b = 0;
        end
        exp_acc_a += p;
        if (exp_acc_a > smax(ACC_A))      begin exp_acc_a = smax(ACC_A);      exp_sat_a = 1; end
        if (exp_acc_a < -smax(ACC_A) - 1) begin exp_acc_a = -smax(ACC_A) - 1; exp_sat_a = 1; end
        exp_acc_b += p;
        if (exp_acc_b > smax(ACC_B))      begin exp_acc_b = smax(ACC_B);      exp_sat_b = 1; end
        if (exp_acc_b < -smax(ACC_B) - 1) begin exp_acc_b = -smax(ACC_B) - 1; exp_sat_b = 1; end
        exp_ws_a += w;
        if (exp_ws_a > umax(WSUM_A)) begin exp_ws_a = umax(WSUM_A); exp_sat_a = 1; end
        exp_ws_b += w;
        if (exp_ws_b > umax(WSUM_B)) begin exp_ws_b = umax(WSUM_B); exp_sat_b = 1; end
        exp_cnt++;
    endtask

    task automatic check_outputs(input bit trunc);
        chk("m_valid_a", mv_a, 1);
        chk("m_valid_b", mv_b, 1);
        chk("s_ready_hold_a", rdy_a, 0);
        chk("s_ready_hold_b", rdy_b, 0);
        chk("m_sum_prod_a", longint'($signed(sp_a)), exp_acc_a);
        chk("m_sum_prod_b", longint'($signed(sp_b)), exp_acc_b);
        chk("m_sum_wt_a", sw_a, exp_ws_a);
        chk("m_sum_wt_b", sw_b, exp_ws_b);
        chk("m_count_a", cnt_a, exp_cnt);
        chk("m_count_b", cnt_b, exp_cnt);
        chk("m_sat_a", sat_a, exp_sat_a);
        chk("m_sat_b", sat_b, exp_sat_b);
        chk("m_trunc_a", trunc_a, trunc);
        chk("m_trunc_b", trunc_b, trunc);
    endtask

    // Result must appear one edge after the end beat, stay stable through
    // the stall, block new beats, and clear after the handshake edge.
    task automatic result_phase(input bit trunc, input int stall);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check_outputs(trunc);
            m_ready = (i == stall);
            s_valid = 1'($urandom_range(0, 1));
            s_prod  = PROD_W'($urandom);
            s_wt    = WT_W'($urandom);
            s_last  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("m_valid_clr_a", mv_a, 0);
        chk("m_valid_clr_b", mv_b, 0);
        chk("s_ready_idle_a", rdy_a, 1);
        m_ready = 1'b0;
        s_valid = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic beat(input logic [PROD_W-1:0] p, input logic [WT_W-1:0] w,
                        input bit last, input bit bubble, input int stall);
        bit ended;
        if (bubble) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_prod  = PROD_W'($urandom);
            s_last  = 1'b1;
        end
        @(negedge clk);
        chk("s_ready_a", rdy_a, 1);
        chk("s_ready_b", rdy_b, 1);
        chk("m_valid_pre", mv_a, 0);
        s_prod  = p;
        s_wt    = w;
        s_last  = last;
        s_valid = 1'b1;
        m_ready = 1'($urandom_range(0, 1));
        model_add(longint'($signed(p)), longint'(w));
        ended = last || (exp_cnt == MAXS);
        @(posedge clk);
        if (ended) result_phase(!last, stall);
    endtask

    function automatic logic [PROD_W-1:0] rand_prod();
        case ($urandom_range(0, 3))
            0: return {1'b0, {(PROD_W-1){1'b1}}};
            1: return {1'b1, {(PROD_W-1){1'b0}}};
            default: return PROD_W'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_s_ready", rdy_a, 0);
        chk("rst_m_valid", mv_a, 0);
        chk("rst_sum_prod", longint'($signed(sp_a)), 0);
        chk("rst_count", cnt_a, 0);
        rst_n = 1'b1;

        // Three-beat window and a single full-scale beat.
        beat(24'd100, 16'd1, 0, 0, 0);
        beat(-24'sd50, 16'd2, 0, 0, 0);
        beat(24'd25, 16'd3, 1, 0, 0);
        beat(24'h800000, 16'hFFFF, 1, 0, 1);

        // Long stall with input offered; next window contains only new beats.
        beat(24'd9, 16'd4, 0, 0, 0);
        beat(24'd11, 16'd5, 1, 0, 5);
        beat(24'd3, 16'd1, 1, 0, 0);

        // Forced end at MAX_SAMPLES, then a fresh window on the next beat.
        for (int i = 0; i < MAXS; i++) beat(24'd1, 16'd1, 0, 0, 2);
        beat(24'd5, 16'd2, 1, 0, 0);
        // Forced end and s_last on the same beat.
        for (int i = 0; i < MAXS - 1; i++) beat(24'd2, 16'd1, 0, 0, 0);
        beat(24'd2, 16'd1, 1, 0, 0);

        // Narrow accumulator: near full scale, then true saturation, then clear.
        beat(24'd8388607, 16'd1, 0, 0, 0);
        beat(24'd8388607, 16'd1, 1, 0, 0);
        for (int i = 0; i < 3; i++) beat(24'd8388607, 16'd1, i == 2, 0, 0);
        beat(24'd1, 16'd1, 1, 0, 0);

        // Reset mid-window discards the partial sums.
        beat(24'd40, 16'd3, 0, 0, 0);
        beat(24'd41, 16'd3, 0, 0, 0);
        @(negedge clk);
        s_valid = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rst_mid_s_ready_a", rdy_a, 0);
        chk("rst_mid_s_ready_b", rdy_b, 0);
        chk("rst_mid_m_valid", mv_a, 0);
        chk("rst_mid_sum_prod", longint'($signed(sp_a)), 0);
        chk("rst_mid_sum_wt", sw_a, 0);
        chk("rst_mid_count", cnt_b, 0);
        chk("rst_mid_trunc", trunc_a, 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        exp_cnt = 0;
        beat(24'd7, 16'd1, 1, 0, 0);

        // Randomized windows with bubbles, stalls and extreme products.
        for (int wnd = 0; wnd < 40; wnd++) begin
            int len;
            bit long_win;
            long_win = ($urandom_range(0, 19) == 0);
            len = long_win ? MAXS + int'($urandom_range(0, 3)) : int'($urandom_range(1, 24));
            for (int k = 0; k < len; k++)
                beat(rand_prod(), WT_W'($urandom), (k == len - 1),
                     ($urandom_range(0, 4) == 0), int'($urandom_range(0, 4)));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
